// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared types and response codes for the AXI4-Lite command master.
package axi_lite_cmd_master_pkg;

    typedef enum logic [2:0] {
        Idle_St,
        Wr_St,
        WrResp_St,
        Rd_St,
        RdData_St
    } Axi_Master_State_Type;

    localparam logic [1:0] Axi_RespOkay_Con    = 2'b00;
    localparam logic [1:0] Axi_RespSlvErr_Con  = 2'b10;
    localparam logic [1:0] Axi_RespDecErr_Con  = 2'b11;
    // Shares its code with DECERR: a timeout looks like "no slave there" to the command source.
    localparam logic [1:0] Axi_RespTimeout_Con = 2'b11;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: one single-beat read or write per command, with a response pulse and an
// access timeout. Reset SysRstN_RstIn is asynchronous and active-high despite its name.
//
// state      | meaning
// Idle_St    | waiting for a command, CmdReady high
// Wr_St      | AW and W valids outstanding, each drops on its own handshake
// WrResp_St  | both write handshakes done, B ready high
// Rd_St      | AR valid outstanding
// RdData_St  | AR accepted, R ready high
module axi_lite_cmd_master
    import axi_lite_cmd_master_pkg::*;
#(
    parameter int unsigned TimeoutCycles_Gen = 1024
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRstN_RstIn,
    input  logic        CmdValid_ValIn,
    output logic        CmdReady_RdyOut,
    input  logic        CmdWrite_EnaIn,
    input  logic [31:0] CmdAddress_AdrIn,
    input  logic [31:0] CmdData_DatIn,
    output logic        RspValid_ValOut,
    output logic [31:0] RspData_DatOut,
    output logic [1:0]  RspResponse_DatOut,
    output logic        AxiWriteAddrValid_ValOut,
    input  logic        AxiWriteAddrReady_RdyIn,
    output logic [31:0] AxiWriteAddrAddress_AdrOut,
    output logic        AxiWriteDataValid_ValOut,
    input  logic        AxiWriteDataReady_RdyIn,
    output logic [31:0] AxiWriteDataData_DatOut,
    output logic [3:0]  AxiWriteDataStrobe_DatOut,
    input  logic        AxiWriteRespValid_ValIn,
    output logic        AxiWriteRespReady_RdyOut,
    input  logic [1:0]  AxiWriteRespResponse_DatIn,
    output logic        AxiReadAddrValid_ValOut,
    input  logic        AxiReadAddrReady_RdyIn,
    output logic [31:0] AxiReadAddrAddress_AdrOut,
    input  logic        AxiReadDataValid_ValIn,
    output logic        AxiReadDataReady_RdyOut,
    input  logic [1:0]  AxiReadDataResponse_DatIn,
    input  logic [31:0] AxiReadDataData_DatIn
);

    localparam int CntWidth_Con = (TimeoutCycles_Gen == 0) ? 1 : $clog2(TimeoutCycles_Gen + 1);
    // The counter is loaded with 1 on accept, so reaching this value at an edge puts the abort
    // pulse exactly TimeoutCycles_Gen cycles after the accept cycle.
    localparam logic [CntWidth_Con-1:0] TimeoutLast_Con =
        CntWidth_Con'((TimeoutCycles_Gen == 0) ? 0 : TimeoutCycles_Gen - 1);

    Axi_Master_State_Type state, stateNext;
    logic                    cmdReady, cmdReadyNext;
    logic                    awValid, awValidNext;
    logic                    wValid, wValidNext;
    logic                    bReady, bReadyNext;
    logic                    arValid, arValidNext;
    logic                    rReady, rReadyNext;
    logic                    rspValid, rspValidNext;
    logic [31:0]             rspData, rspDataNext;
    logic [1:0]              rspResp, rspRespNext;
    logic [31:0]             cmdAddress, cmdAddressNext;
    logic [31:0]             cmdData, cmdDataNext;
    logic [CntWidth_Con-1:0] timeoutCnt, timeoutCntNext;
    logic                    timeoutHit;

    assign timeoutHit = (TimeoutCycles_Gen != 0) && (state != Idle_St) &&
                        (timeoutCnt >= TimeoutLast_Con);

    always_ff @(posedge SysClk_ClkIn or posedge SysRstN_RstIn) begin
        if (SysRstN_RstIn) begin
            state      <= Idle_St;
            cmdReady   <= 1'b0;
            awValid    <= 1'b0;
            wValid     <= 1'b0;
            bReady     <= 1'b0;
            arValid    <= 1'b0;
            rReady     <= 1'b0;
            rspValid   <= 1'b0;
            rspData    <= '0;
            rspResp    <= '0;
            cmdAddress <= '0;
            cmdData    <= '0;
            timeoutCnt <= '0;
        end else begin
            state      <= stateNext;
            cmdReady   <= cmdReadyNext;
            awValid    <= awValidNext;
            wValid     <= wValidNext;
            bReady     <= bReadyNext;
            arValid    <= arValidNext;
            rReady     <= rReadyNext;
            rspValid   <= rspValidNext;
            rspData    <= rspDataNext;
            rspResp    <= rspRespNext;
            cmdAddress <= cmdAddressNext;
            cmdData    <= cmdDataNext;
            timeoutCnt <= timeoutCntNext;
        end
    end

    always_comb begin
        stateNext      = state;
        cmdReadyNext   = cmdReady;
        awValidNext    = awValid;
        wValidNext     = wValid;
        bReadyNext     = bReady;
        arValidNext    = arValid;
        rReadyNext     = rReady;
        rspValidNext   = 1'b0;
        rspDataNext    = rspData;
        rspRespNext    = rspResp;
        cmdAddressNext = cmdAddress;
        cmdDataNext    = cmdData;
        timeoutCntNext = timeoutCnt;
        if (state != Idle_St) begin
            timeoutCntNext = timeoutCnt + CntWidth_Con'(1);
        end

        case (state)
            Idle_St: begin
                cmdReadyNext = 1'b1;
                if (CmdValid_ValIn && cmdReady) begin
                    cmdReadyNext   = 1'b0;
                    cmdAddressNext = CmdAddress_AdrIn;
                    cmdDataNext    = CmdData_DatIn;
                    timeoutCntNext = CntWidth_Con'(1);
                    if (CmdWrite_EnaIn) begin
                        awValidNext = 1'b1;
                        wValidNext  = 1'b1;
                        stateNext   = Wr_St;
                    end else begin
                        arValidNext = 1'b1;
                        stateNext   = Rd_St;
                    end
                end
            end
            Wr_St: begin
                if (awValid && AxiWriteAddrReady_RdyIn) awValidNext = 1'b0;
                if (wValid && AxiWriteDataReady_RdyIn)  wValidNext  = 1'b0;
                if (!awValidNext && !wValidNext) begin
                    bReadyNext = 1'b1;
                    stateNext  = WrResp_St;
                end
            end
            WrResp_St: begin
                if (bReady && AxiWriteRespValid_ValIn) begin
                    bReadyNext   = 1'b0;
                    rspValidNext = 1'b1;
                    rspRespNext  = AxiWriteRespResponse_DatIn;
                    rspDataNext  = '0;
                    stateNext    = Idle_St;
                end
            end
            Rd_St: begin
                if (arValid && AxiReadAddrReady_RdyIn) begin
                    arValidNext = 1'b0;
                    rReadyNext  = 1'b1;
                    stateNext   = RdData_St;
                end
            end
            RdData_St: begin
                if (rReady && AxiReadDataValid_ValIn) begin
                    rReadyNext   = 1'b0;
                    rspValidNext = 1'b1;
                    rspRespNext  = AxiReadDataResponse_DatIn;
                    rspDataNext  = AxiReadDataData_DatIn;
                    stateNext    = Idle_St;
                end
            end
            default: stateNext = Idle_St;
        endcase

        // A response beat landing on the abort edge still completes normally.
        if (timeoutHit && !rspValidNext) begin
            awValidNext  = 1'b0;
            wValidNext   = 1'b0;
            bReadyNext   = 1'b0;
            arValidNext  = 1'b0;
            rReadyNext   = 1'b0;
            rspValidNext = 1'b1;
            rspRespNext  = Axi_RespTimeout_Con;
            rspDataNext  = '0;
            stateNext    = Idle_St;
        end
    end

    assign CmdReady_RdyOut            = cmdReady;
    assign RspValid_ValOut            = rspValid;
    assign RspData_DatOut             = rspData;
    assign RspResponse_DatOut         = rspResp;
    assign AxiWriteAddrValid_ValOut   = awValid;
    assign AxiWriteAddrAddress_AdrOut = cmdAddress;
    assign AxiWriteDataValid_ValOut   = wValid;
    assign AxiWriteDataData_DatOut    = cmdData;
    assign AxiWriteDataStrobe_DatOut  = (state == Wr_St) ? 4'hF : 4'h0;
    assign AxiWriteRespReady_RdyOut   = bReady;
    assign AxiReadAddrValid_ValOut    = arValid;
    assign AxiReadAddrAddress_AdrOut  = cmdAddress;
    assign AxiReadDataReady_RdyOut    = rReady;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed plus randomized bench for axi_lite_cmd_master against a cycle-arithmetic model.
module tb_axi_lite_cmd_master;

    localparam int Timeout_Con = 16;
    localparam int Silent_Con  = 99;

    logic        SysClk_ClkIn;
    logic        SysRstN_RstIn;
    logic        CmdValid_ValIn;
    logic        CmdReady_RdyOut;
    logic        CmdWrite_EnaIn;
    logic [31:0] CmdAddress_AdrIn;
    logic [31:0] CmdData_DatIn;
    logic        RspValid_ValOut;
    logic [31:0] RspData_DatOut;
    logic [1:0]  RspResponse_DatOut;
    logic        AxiWriteAddrValid_ValOut;
    logic        AxiWriteAddrReady_RdyIn;
    logic [31:0] AxiWriteAddrAddress_AdrOut;
    logic        AxiWriteDataValid_ValOut;
    logic        AxiWriteDataReady_RdyIn;
    logic [31:0] AxiWriteDataData_DatOut;
    logic [3:0]  AxiWriteDataStrobe_DatOut;
    logic        AxiWriteRespValid_ValIn;
    logic        AxiWriteRespReady_RdyOut;
    logic [1:0]  AxiWriteRespResponse_DatIn;
    logic        AxiReadAddrValid_ValOut;
    logic        AxiReadAddrReady_RdyIn;
    logic [31:0] AxiReadAddrAddress_AdrOut;
    logic        AxiReadDataValid_ValIn;
    logic        AxiReadDataReady_RdyOut;
    logic [1:0]  AxiReadDataResponse_DatIn;
    logic [31:0] AxiReadDataData_DatIn;

    axi_lite_cmd_master #(.TimeoutCycles_Gen(Timeout_Con)) dut (
        .SysClk_ClkIn              (SysClk_ClkIn),
        .SysRstN_RstIn             (SysRstN_RstIn),
        .CmdValid_ValIn            (CmdValid_ValIn),
        .CmdReady_RdyOut           (CmdReady_RdyOut),
        .CmdWrite_EnaIn            (CmdWrite_EnaIn),
        .CmdAddress_AdrIn          (CmdAddress_AdrIn),
        .CmdData_DatIn             (CmdData_DatIn),
        .RspValid_ValOut           (RspValid_ValOut),
        .RspData_DatOut            (RspData_DatOut),
        .RspResponse_DatOut        (RspResponse_DatOut),
        .AxiWriteAddrValid_ValOut  (AxiWriteAddrValid_ValOut),
        .AxiWriteAddrReady_RdyIn   (AxiWriteAddrReady_RdyIn),
        .AxiWriteAddrAddress_AdrOut(AxiWriteAddrAddress_AdrOut),
        .AxiWriteDataValid_ValOut  (AxiWriteDataValid_ValOut),
        .AxiWriteDataReady_RdyIn   (AxiWriteDataReady_RdyIn),
        .AxiWriteDataData_DatOut   (AxiWriteDataData_DatOut),
        .AxiWriteDataStrobe_DatOut (AxiWriteDataStrobe_DatOut),
        .AxiWriteRespValid_ValIn   (AxiWriteRespValid_ValIn),
        .AxiWriteRespReady_RdyOut  (AxiWriteRespReady_RdyOut),
        .AxiWriteRespResponse_DatIn(AxiWriteRespResponse_DatIn),
        .AxiReadAddrValid_ValOut   (AxiReadAddrValid_ValOut),
        .AxiReadAddrReady_RdyIn    (AxiReadAddrReady_RdyIn),
        .AxiReadAddrAddress_AdrOut (AxiReadAddrAddress_AdrOut),
        .AxiReadDataValid_ValIn    (AxiReadDataValid_ValIn),
        .AxiReadDataReady_RdyOut   (AxiReadDataReady_RdyOut),
        .AxiReadDataResponse_DatIn (AxiReadDataResponse_DatIn),
        .AxiReadDataData_DatIn     (AxiReadDataData_DatIn)
    );

    int nAsserts = 0;
    int nFails   = 0;

    // Slave wait states: cycles each ready/valid lags the master's valid/ready.
    int          cfgAwD = 0, cfgWD = 0, cfgBD = 0, cfgArD = 0, cfgRD = 0;
    logic [1:0]  cfgBResp = 2'b00, cfgRResp = 2'b00;
    logic [31:0] cfgRData = '0;

    logic [140:0] allOuts;
    assign allOuts = {CmdReady_RdyOut, RspValid_ValOut, RspData_DatOut, RspResponse_DatOut,
                      AxiWriteAddrValid_ValOut, AxiWriteAddrAddress_AdrOut,
                      AxiWriteDataValid_ValOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut,
                      AxiWriteRespReady_RdyOut, AxiReadAddrValid_ValOut, AxiReadAddrAddress_AdrOut,
                      AxiReadDataReady_RdyOut};

    logic [6:0] ctlOuts;
    assign ctlOuts = {CmdReady_RdyOut, RspValid_ValOut, AxiWriteAddrValid_ValOut,
                      AxiWriteDataValid_ValOut, AxiWriteRespReady_RdyOut,
                      AxiReadAddrValid_ValOut, AxiReadDataReady_RdyOut};

    initial begin
        SysClk_ClkIn = 1'b0;
        forever #5 SysClk_ClkIn = ~SysClk_ClkIn;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected end before 200000");
        $fatal(1);
    end

    // Behavioural slave, updated just after each clock edge.
    initial begin
        int awCnt, wCnt, bCnt, arCnt, rCnt;
        awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
        AxiWriteAddrReady_RdyIn = 1'b0; AxiWriteDataReady_RdyIn = 1'b0;
        AxiWriteRespValid_ValIn = 1'b0; AxiWriteRespResponse_DatIn = 2'b00;
        AxiReadAddrReady_RdyIn = 1'b0; AxiReadDataValid_ValIn = 1'b0;
        AxiReadDataResponse_DatIn = 2'b00; AxiReadDataData_DatIn = '0;
        forever begin
            @(posedge SysClk_ClkIn);
            #1;
            if (!AxiWriteAddrValid_ValOut) begin awCnt = 0; AxiWriteAddrReady_RdyIn = 1'b0; end
            else begin AxiWriteAddrReady_RdyIn = (awCnt >= cfgAwD); awCnt++; end
            if (!AxiWriteDataValid_ValOut) begin wCnt = 0; AxiWriteDataReady_RdyIn = 1'b0; end
            else begin AxiWriteDataReady_RdyIn = (wCnt >= cfgWD); wCnt++; end
            if (!AxiWriteRespReady_RdyOut) begin bCnt = 0; AxiWriteRespValid_ValIn = 1'b0; end
            else begin AxiWriteRespValid_ValIn = (bCnt >= cfgBD); bCnt++; end
            if (!AxiReadAddrValid_ValOut) begin arCnt = 0; AxiReadAddrReady_RdyIn = 1'b0; end
            else begin AxiReadAddrReady_RdyIn = (arCnt >= cfgArD); arCnt++; end
            if (!AxiReadDataReady_RdyOut) begin rCnt = 0; AxiReadDataValid_ValIn = 1'b0; end
            else begin AxiReadDataValid_ValIn = (rCnt >= cfgRD); rCnt++; end
            AxiWriteRespResponse_DatIn = cfgBResp;
            AxiReadDataResponse_DatIn  = cfgRResp;
            AxiReadDataData_DatIn      = cfgRData;
        end
    end

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge SysClk_ClkIn);
        #2;
    endtask

    // Issues one command in the current cycle (CmdReady must be high) and follows it through
    // the response pulse, comparing every cycle against expectations derived from the wait states.
    task automatic runCmd(input string tag, input logic wr, input logic [31:0] adr,
                          input logic [31:0] dat, input int awD, input int wD, input int bD,
                          input int arD, input int rD, input logic [1:0] bRsp,
                          input logic [1:0] rRsp, input logic [31:0] rDat);
        int m, lat, e;
        logic [1:0]  expResp;
        logic [31:0] expData;
        logic [6:0]  expCtl;
        cfgAwD = awD; cfgWD = wD; cfgBD = bD; cfgArD = arD; cfgRD = rD;
        cfgBResp = bRsp; cfgRResp = rRsp; cfgRData = rDat;
        m   = (awD > wD) ? awD : wD;
        lat = wr ? (3 + m + bD) : (3 + arD + rD);
        if (lat > Timeout_Con) begin
            e = Timeout_Con; expResp = 2'b11; expData = '0;
        end else begin
            e = lat; expResp = wr ? bRsp : rRsp; expData = wr ? 32'h0 : rDat;
        end
        check({tag, "/ready_before"}, 192'(CmdReady_RdyOut), 192'(1'b1));
        CmdValid_ValIn = 1'b1; CmdWrite_EnaIn = wr; CmdAddress_AdrIn = adr; CmdData_DatIn = dat;
        for (int k = 1; k <= e; k++) begin
            nextCycle();
            if (k == 1) begin
                CmdValid_ValIn = 1'b0; CmdWrite_EnaIn = $urandom_range(0, 1);
                CmdAddress_AdrIn = $urandom; CmdData_DatIn = $urandom;
            end
            expCtl = {1'b0, (k == e),
                      (k < e) && wr && (k <= 1 + awD),
                      (k < e) && wr && (k <= 1 + wD),
                      (k < e) && wr && (k >= 2 + m),
                      (k < e) && !wr && (k <= 1 + arD),
                      (k < e) && !wr && (k >= 2 + arD)};
            check($sformatf("%s/ctl k=%0d", tag, k), 192'(ctlOuts), 192'(expCtl));
            if (k == 1 && wr)
                check({tag, "/aw_w_payload"},
                      192'({AxiWriteAddrAddress_AdrOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut}),
                      192'({adr, dat, 4'hF}));
            if (k == 1 && !wr)
                check({tag, "/ar_payload"},
                      192'({AxiReadAddrAddress_AdrOut, AxiWriteDataStrobe_DatOut}), 192'({adr, 4'h0}));
            if (k == e)
                check({tag, "/rsp"}, 192'({RspData_DatOut, RspResponse_DatOut}), 192'({expData, expResp}));
        end
        nextCycle();
        check({tag, "/ctl_after"}, 192'(ctlOuts), 192'(7'b1000000));
        check({tag, "/rsp_held"}, 192'({RspData_DatOut, RspResponse_DatOut}), 192'({expData, expResp}));
    endtask

    initial begin
        logic        wr;
        logic [31:0] adr, dat, rDat;
        int          d[5];
        logic [1:0]  bRsp, rRsp;

        SysRstN_RstIn = 1'b1;
        CmdValid_ValIn = 1'b0; CmdWrite_EnaIn = 1'b0; CmdAddress_AdrIn = '0; CmdData_DatIn = '0;
        repeat (3) nextCycle();
        check("reset_outputs", 192'(allOuts), 192'(0));
        SysRstN_RstIn = 1'b0;
        #1;
        check("release_ready_low", 192'(CmdReady_RdyOut), 192'(1'b0));
        nextCycle();
        check("release_ready_high", 192'(ctlOuts), 192'(7'b1000000));

        runCmd("wr_zero_wait", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        runCmd("wr_aw2_w5", 1'b1, 32'h0000_2004, 32'h1234_5678, 1, 4, 0, 0, 0, 2'b00, 2'b00, 0);
        runCmd("rd_wait3", 1'b0, 32'h0000_0000, 32'h0, 0, 0, 0, 0, 3, 2'b00, 2'b00, 32'h0001_0002);
        runCmd("rd_silent", 1'b0, 32'h0000_3000, 32'h0, 0, 0, 0, Silent_Con, 0, 2'b00, 2'b00, 32'hFFFF_FFFF);
        runCmd("wr_no_bresp", 1'b1, 32'h0000_4000, 32'hA5A5_A5A5, 0, 0, Silent_Con, 0, 0, 2'b00, 2'b00, 0);
        runCmd("wr_no_awready", 1'b1, 32'h0000_4004, 32'h5A5A_5A5A, Silent_Con, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        runCmd("wr_slverr", 1'b1, 32'h0000_5000, 32'h0BAD_F00D, 2, 0, 3, 0, 0, 2'b10, 2'b00, 0);
        runCmd("rd_decerr", 1'b0, 32'h0000_6000, 32'h0, 0, 0, 0, 1, 1, 2'b00, 2'b11, 32'h0000_0000);
        runCmd("rd_edge_16", 1'b0, 32'h0000_7000, 32'h0, 0, 0, 0, 6, 7, 2'b00, 2'b00, 32'hCAFE_0016);
        runCmd("rd_edge_17", 1'b0, 32'h0000_7004, 32'h0, 0, 0, 0, 6, 8, 2'b00, 2'b00, 32'hCAFE_0017);

        // Back-to-back: CmdValid stays high across two commands.
        cfgAwD = 0; cfgWD = 0; cfgBD = 0; cfgArD = 0; cfgRD = 0;
        cfgBResp = 2'b00; cfgRResp = 2'b00; cfgRData = 32'h7777_8888;
        check("b2b/ready", 192'(CmdReady_RdyOut), 192'(1'b1));
        CmdValid_ValIn = 1'b1; CmdWrite_EnaIn = 1'b1; CmdAddress_AdrIn = 32'h100; CmdData_DatIn = 32'h11;
        nextCycle();
        CmdWrite_EnaIn = 1'b0; CmdAddress_AdrIn = 32'h200; CmdData_DatIn = 32'h22;
        nextCycle();
        nextCycle();
        check("b2b/first_rsp", 192'({ctlOuts, RspData_DatOut, RspResponse_DatOut}),
              192'({7'b0100000, 32'h0, 2'b00}));
        nextCycle();
        check("b2b/ready_again", 192'(ctlOuts), 192'(7'b1000000));
        nextCycle();
        CmdValid_ValIn = 1'b0;
        check("b2b/second_ar", 192'({ctlOuts, AxiReadAddrAddress_AdrOut}), 192'({7'b0000010, 32'h200}));
        nextCycle();
        nextCycle();
        check("b2b/second_rsp", 192'({ctlOuts, RspData_DatOut, RspResponse_DatOut}),
              192'({7'b0100000, 32'h7777_8888, 2'b00}));
        nextCycle();
        check("b2b/ready_end", 192'(ctlOuts), 192'(7'b1000000));

        // Reset while AR valid is high abandons the read without a response.
        cfgArD = Silent_Con;
        CmdValid_ValIn = 1'b1; CmdWrite_EnaIn = 1'b0; CmdAddress_AdrIn = 32'h0000_9000;
        nextCycle();
        CmdValid_ValIn = 1'b0;
        check("rst_mid/ar_valid", 192'(AxiReadAddrValid_ValOut), 192'(1'b1));
        nextCycle();
        SysRstN_RstIn = 1'b1;
        #1;
        check("rst_mid/outputs", 192'(allOuts), 192'(0));
        nextCycle();
        check("rst_mid/held", 192'(allOuts), 192'(0));
        SysRstN_RstIn = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            check($sformatf("rst_mid/after k=%0d", k), 192'(ctlOuts), 192'(7'b1000000));
        end

        for (int i = 0; i < 24; i++) begin
            wr  = $urandom_range(0, 1);
            adr = $urandom & 32'hFFFF_FFFC;
            dat = $urandom;
            rDat = $urandom;
            bRsp = 2'($urandom_range(0, 3));
            rRsp = 2'($urandom_range(0, 3));
            d[0] = $urandom_range(0, 5); d[1] = $urandom_range(0, 5); d[2] = $urandom_range(0, 4);
            d[3] = $urandom_range(0, 6); d[4] = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 4)] = Silent_Con;
            runCmd($sformatf("rand%0d", i), wr, adr, dat, d[0], d[1], d[2], d[3], d[4], bRsp, rRsp, rDat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
